// File: rtl/pio_pkg.sv
// Shared register map, edge-type encoding and edge-detect helper for the Avalon PIO block.
package pio_pkg;

  localparam logic [2:0] REG_DATA     = 3'd0;
  localparam logic [2:0] REG_DIR      = 3'd1;
  localparam logic [2:0] REG_IRQ_MASK = 3'd2;
  localparam logic [2:0] REG_EDGE_CAP = 3'd3;
  localparam logic [2:0] REG_OUTSET   = 3'd4;
  localparam logic [2:0] REG_OUTCLR   = 3'd5;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_ANY  = 2'd2
  } edge_type_e;

  function automatic logic edge_hit(input logic sync, input logic prev, input edge_type_e etype);
    case (etype)
      EDGE_RISE: return sync & ~prev;
      EDGE_FALL: return ~sync & prev;
      EDGE_ANY:  return sync ^ prev;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pio_edge_sync.sv
// Input synchroniser, one-cycle history and arm-gated per-bit edge detector for the PIO inputs.
module pio_edge_sync
  import pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] sync_in,
  output logic [WIDTH-1:0] edge_pulse
);

  localparam edge_type_e ETYPE     = edge_type_e'(EDGE_TYPE[1:0]);
  localparam int         ARM_COUNT = SYNC_STAGES + 1;
  localparam int         ARM_W     = $clog2(ARM_COUNT + 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0]                  prev_q, prev_d;
  logic [ARM_W-1:0]                  arm_cnt_q, arm_cnt_d;
  logic                              armed;

  assign sync_in = sync_q[SYNC_STAGES-1];
  assign armed   = (arm_cnt_q == ARM_W'(ARM_COUNT));

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = pin_in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    prev_d    = sync_in;
    arm_cnt_d = armed ? arm_cnt_q : arm_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q    <= '0;
      prev_q    <= '0;
      arm_cnt_q <= '0;
    end else begin
      sync_q    <= sync_d;
      prev_q    <= prev_d;
      arm_cnt_q <= arm_cnt_d;
    end
  end

  // Until the chain has flushed the reset zeros, a pin held high would look like an edge.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_edge
      assign edge_pulse[gi] = armed & edge_hit(sync_in[gi], prev_q[gi], ETYPE);
    end
  endgenerate

endmodule

// File: rtl/avalon_pio_ctrl.sv
// Avalon-MM GPIO slave: data/direction/mask/edge-capture registers and a maskable level irq.
// Define PIO_OUTSETCLR_EN to enable the atomic OUTSET/OUTCLR registers at word addresses 4/5.
module avalon_pio_ctrl
  import pio_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [WIDTH-1:0] DIR_RESET   = '0,
  parameter int               EDGE_TYPE   = 0,
  parameter int               SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] pin_out,
  output logic [WIDTH-1:0] pin_oe,
  output logic             irq
);

  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
  logic [WIDTH-1:0] sync_in, edge_pulse, cap_set, cap_clr, wd, rd_val;
  logic             wr_en;
  logic             unused_ok;

  pio_edge_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_TYPE   (EDGE_TYPE)
  ) u_edge_sync (
    .clk        (clk),
    .reset_n    (reset_n),
    .pin_in     (pin_in),
    .sync_in    (sync_in),
    .edge_pulse (edge_pulse)
  );

  assign wr_en     = chipselect & ~write_n;
  assign wd        = writedata[WIDTH-1:0];
  assign unused_ok = &{1'b0, writedata};
  // Registered dir means an edge coinciding with a DIR write is judged by the old direction.
  assign cap_set   = edge_pulse & ~dir_q;

  always_comb begin
    data_out_d = data_out_q;
    dir_d      = dir_q;
    mask_d     = mask_q;
    cap_clr    = '0;
    if (wr_en) begin
      case (address)
        REG_DATA:     data_out_d = wd;
        REG_DIR:      dir_d      = wd;
        REG_IRQ_MASK: mask_d     = wd;
        REG_EDGE_CAP: cap_clr    = wd;
`ifdef PIO_OUTSETCLR_EN
        REG_OUTSET:   data_out_d = data_out_q | wd;
        REG_OUTCLR:   data_out_d = data_out_q & ~wd;
`endif
        default: ;
      endcase
    end
    // A fresh edge outranks a same-cycle write-1-to-clear.
    edge_cap_d = (edge_cap_q & ~cap_clr) | cap_set;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out_q <= RESET_VALUE;
      dir_q      <= DIR_RESET;
      mask_q     <= '0;
      edge_cap_q <= '0;
    end else begin
      data_out_q <= data_out_d;
      dir_q      <= dir_d;
      mask_q     <= mask_d;
      edge_cap_q <= edge_cap_d;
    end
  end

  always_comb begin
    rd_val = '0;
    case (address)
      REG_DATA:     rd_val = (sync_in & ~dir_q) | (data_out_q & dir_q);
      REG_DIR:      rd_val = dir_q;
      REG_IRQ_MASK: rd_val = mask_q;
      REG_EDGE_CAP: rd_val = edge_cap_q;
      default:      rd_val = '0;
    endcase
    readdata              = '0;
    readdata[WIDTH-1:0]   = rd_val;
  end

  assign pin_out = data_out_q;
  assign pin_oe  = dir_q;
  assign irq     = |(edge_cap_q & mask_q);

endmodule

// File: tb/tb_avalon_pio_ctrl.sv
// Directed scoreboard bench for avalon_pio_ctrl with default parameters (8 bits, rising edge, 2 sync stages).
module tb_avalon_pio_ctrl;
  import pio_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  pin_in;
  logic [7:0]  pin_out;
  logic [7:0]  pin_oe;
  logic        irq;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] rd;

  always #5 clk = ~clk;

  avalon_pio_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .pin_in     (pin_in),
    .pin_out    (pin_out),
    .pin_oe     (pin_oe),
    .irq        (irq)
  );

  task automatic expect_val(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s: observed 0x%08h but no expected value queued", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        n_bad++;
        $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
      $display("check %-14s obs=0x%08h", tag, obs);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    $display("write addr=%0d data=0x%08h", a, d);
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  initial begin
    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    address = '0; writedata = '0; pin_in = 8'hFF;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    expect_val(32'h0); check("rst_irq", {31'b0, irq});
    expect_val(32'h0); check("rst_pin_out", {24'b0, pin_out});
    expect_val(32'h0); check("rst_pin_oe", {24'b0, pin_oe});
    expect_val(32'h0); bus_read(REG_EDGE_CAP, rd); check("rst_edge_cap", rd);

    // Pins high through reset release: visible after 2 cycles, never captured
    @(negedge clk); reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    expect_val(32'h0000_00FF); bus_read(REG_DATA, rd); check("sync_data", rd);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      expect_val(32'h0); check("arm_irq", {31'b0, irq});
      expect_val(32'h0); bus_read(REG_EDGE_CAP, rd); check("arm_edge_cap", rd);
    end

    // Direction and data, upper write bits ignored
    bus_write(REG_DIR, 32'h1234_56F0);
    bus_write(REG_DATA, 32'hFFFF_FFA5);
    expect_val(32'hA5); check("pin_out", {24'b0, pin_out});
    expect_val(32'hF0); check("pin_oe", {24'b0, pin_oe});
    expect_val(32'h0000_00F0); bus_read(REG_DIR, rd); check("dir_rd", rd);
    pin_in = 8'h03;
    repeat (3) @(posedge clk); #1;
    expect_val(32'h0000_00A3); bus_read(REG_DATA, rd); check("data_mixed", rd);
    expect_val(32'h0); bus_read(REG_EDGE_CAP, rd); check("fall_ignored", rd);

    // Rising edge on bit 0: capture and irq exactly two edges after sampling
    pin_in = 8'h02;
    repeat (4) @(posedge clk);
    bus_write(REG_IRQ_MASK, 32'h1);
    expect_val(32'h0); check("mask_irq0", {31'b0, irq});
    expect_val(32'h1); bus_read(REG_IRQ_MASK, rd); check("mask_rd", rd);
    @(negedge clk); pin_in = 8'h03;
    @(posedge clk);
    @(posedge clk); #1;
    expect_val(32'h0); check("lat_k1_irq", {31'b0, irq});
    @(posedge clk); #1;
    expect_val(32'h1); check("lat_k2_irq", {31'b0, irq});
    expect_val(32'h1); bus_read(REG_EDGE_CAP, rd); check("lat_k2_cap", rd);
    bus_write(REG_EDGE_CAP, 32'h1);
    expect_val(32'h0); check("w1c_irq", {31'b0, irq});
    expect_val(32'h0); bus_read(REG_EDGE_CAP, rd); check("w1c_cap", rd);

    // Clear and new edge in the same cycle: set wins
    @(negedge clk); pin_in = 8'h02;
    repeat (4) @(posedge clk);
    @(negedge clk); pin_in = 8'h03;
    @(posedge clk);
    @(posedge clk);
    bus_write(REG_EDGE_CAP, 32'h1);
    expect_val(32'h1); bus_read(REG_EDGE_CAP, rd); check("set_wins_cap", rd);
    expect_val(32'h1); check("set_wins_irq", {31'b0, irq});

    // Output-direction bits never capture
    @(negedge clk); pin_in = 8'hF3;
    repeat (4) @(posedge clk); #1;
    expect_val(32'h1); bus_read(REG_EDGE_CAP, rd); check("out_no_cap", rd);

    // Atomic set/clear and reserved addresses
    bus_write(REG_DATA, 32'h0F);
    expect_val(32'h0F); check("data_0f", {24'b0, pin_out});
    bus_write(REG_OUTSET, 32'h30);
`ifdef PIO_OUTSETCLR_EN
    expect_val(32'h3F);
`else
    expect_val(32'h0F);
`endif
    check("outset", {24'b0, pin_out});
    bus_write(REG_OUTCLR, 32'h05);
`ifdef PIO_OUTSETCLR_EN
    expect_val(32'h3A);
`else
    expect_val(32'h0F);
`endif
    check("outclr", {24'b0, pin_out});
    expect_val(32'h0); bus_read(REG_OUTSET, rd); check("outset_rd", rd);
    bus_write(3'd6, 32'hFF);
    expect_val(32'hF0); check("rsvd_dir", {24'b0, pin_oe});
    expect_val(32'h0); bus_read(3'd6, rd); check("rsvd_rd", rd);

    // Asynchronous reset mid-operation with irq high
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    expect_val(32'h0); check("arst_irq", {31'b0, irq});
    expect_val(32'h0); check("arst_pin_out", {24'b0, pin_out});
    expect_val(32'h0); check("arst_pin_oe", {24'b0, pin_oe});
    expect_val(32'h0); bus_read(REG_EDGE_CAP, rd); check("arst_cap", rd);

    // Arm counter restarts: pins high at release, all bits unmasked, still no irq
    @(negedge clk); reset_n = 1'b1;
    bus_write(REG_IRQ_MASK, 32'hFF);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      expect_val(32'h0); check("rearm_irq", {31'b0, irq});
    end
    expect_val(32'h0); bus_read(REG_EDGE_CAP, rd); check("rearm_cap", rd);

    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard: %0d expected values never compared", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
